// File: rtl/gpu_core.sv
// gpu_core: one 16-bit core of the GPU array; fetches and runs one instruction per go pulse.
// Optional store instruction (opcode 12) is enabled by defining GPU_CORE_STORE_EN.
module gpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  id,
    input  logic        enable,
    input  logic        doNextIns,
    output logic        ready,
    input  logic        overwrite,
    input  logic [15:0] newPC,
    output logic        halted,
    output logic        memRead,
    output logic [15:0] memAddr,
    input  logic        memReady,
    input  logic [15:0] memData,
    output logic        memWrite,
    output logic [15:0] memWriteAddr,
    output logic [15:0] memWriteData,
    output logic        spawn,
    output logic [3:0]  spawnID,
    output logic [15:0] spawnPC,
    output logic        sync,
    output logic [15:0] syncGroup
);

    localparam logic [3:0] OP_MOV  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_HALT = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_LDR  = 4'd5;
    localparam logic [3:0] OP_JEQ  = 4'd6;
    localparam logic [3:0] OP_JLT  = 4'd7;
    localparam logic [3:0] OP_JGT  = 4'd8;
    localparam logic [3:0] OP_SYNC = 4'd10;
    localparam logic [3:0] OP_SPWN = 4'd11;
`ifdef GPU_CORE_STORE_EN
    localparam logic [3:0] OP_ST   = 4'd12;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic [15:0] rf_q [16];

    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic [3:0]  op, ra, rb, rc;
    logic [15:0] va, vb, vc;
    logic        commit;
    logic        unused_id;

    assign op = ir_q[15:12];
    assign ra = ir_q[11:8];
    assign rb = ir_q[7:4];
    assign rc = ir_q[3:0];
    assign va = rf_q[ra];
    assign vb = rf_q[rb];
    assign vc = rf_q[rc];

    // core index only matters to the array controller
    assign unused_id = ^id;

    assign commit = (state_q == S_EXEC) && doNextIns && enable && !overwrite;
    assign halted = halted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_FETCH;
            S_FETCH: if (memReady) state_d = S_EXEC;
            S_EXEC: begin
                if (doNextIns) begin
                    if (op == OP_LD || op == OP_LDR)
                        state_d = S_MEM;
                    else if (op == OP_HALT)
                        state_d = S_HALT;
                    else
                        state_d = S_FETCH;
                end
            end
            S_MEM:   if (memReady) state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;
        if (overwrite) state_d = enable ? S_FETCH : S_IDLE;
    end

    always_comb begin
        memRead      = 1'b0;
        memAddr      = '0;
        ready        = 1'b0;
        spawn        = 1'b0;
        spawnID      = '0;
        spawnPC      = '0;
        sync         = 1'b0;
        syncGroup    = '0;
        memWrite     = 1'b0;
        memWriteAddr = '0;
        memWriteData = '0;
        unique case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                memAddr = pc_q;
            end
            S_MEM: begin
                memRead = 1'b1;
                memAddr = (op == OP_LD) ? {8'h00, ir_q[7:0]} : vb;
            end
            S_EXEC: begin
                ready = 1'b1;
                if (doNextIns) begin
                    case (op)
                        OP_SPWN: begin
                            spawn   = 1'b1;
                            spawnID = ra;
                            spawnPC = vb;
                        end
                        OP_SYNC: begin
                            sync      = 1'b1;
                            syncGroup = {12'h000, rc};
                        end
`ifdef GPU_CORE_STORE_EN
                        OP_ST: begin
                            memWrite     = 1'b1;
                            memWriteAddr = vb;
                            memWriteData = va;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_waddr = ra;
        rf_wdata = '0;
        if (state_q == S_FETCH && memReady && enable) ir_d = memData;
        if (commit) begin
            pc_d = pc_q + 16'd1;
            case (op)
                OP_MOV: begin
                    rf_we    = 1'b1;
                    rf_wdata = {8'h00, ir_q[7:0]};
                end
                OP_ADD: begin
                    rf_we    = 1'b1;
                    rf_wdata = vb + vc;
                end
                OP_JMP:  pc_d = {4'h0, ir_q[11:0]};
                OP_HALT: halted_d = 1'b1;
                OP_JEQ:  if (va == vb) pc_d = vc;
                OP_JLT:  if (va < vb) pc_d = vc;
                OP_JGT:  if (va > vb) pc_d = vc;
                default: ;
            endcase
        end
        if (state_q == S_MEM && memReady && enable && !overwrite) begin
            rf_we    = 1'b1;
            rf_wdata = memData;
        end
        if (overwrite) begin
            pc_d     = newPC;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_gpu_core.sv
// tb_gpu_core: table-driven programs plus hand sequences; a scoreboard
// queue holds the spawn/sync/store pulses each program must produce.
module tb_gpu_core;

    logic        clk, reset, enable, doNextIns, ready, overwrite, halted;
    logic        memRead, memReady, memWrite, spawn, sync;
    logic [3:0]  id, spawnID;
    logic [15:0] newPC, memAddr, memData, memWriteAddr, memWriteData;
    logic [15:0] spawnPC, syncGroup;

    logic [15:0] mem [0:65535];
    assign memData  = mem[memAddr];
    assign memReady = 1'b1;
    assign id       = 4'd3;

    gpu_core dut (
        .clk(clk), .reset(reset), .id(id), .enable(enable),
        .doNextIns(doNextIns), .ready(ready), .overwrite(overwrite),
        .newPC(newPC), .halted(halted), .memRead(memRead),
        .memAddr(memAddr), .memReady(memReady), .memData(memData),
        .memWrite(memWrite), .memWriteAddr(memWriteAddr),
        .memWriteData(memWriteData), .spawn(spawn), .spawnID(spawnID),
        .spawnPC(spawnPC), .sync(sync), .syncGroup(syncGroup)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  eid;
        logic [15:0] epc;
    } vec_t;

    ev_t  sb[$];
    vec_t tbl[10];
    int   total = 0;
    int   bad = 0;
    int   wcount = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] a,
                        input logic [15:0] b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic got(input logic [1:0] k, input logic [15:0] a,
                       input logic [15:0] b);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: kind %0d a=%h b=%h", k, a, b);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", {14'h0, k}, {14'h0, e.kind});
            chk("ev_a", a, e.a);
            chk("ev_b", b, e.b);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (spawn) got(2'd1, {12'h0, spawnID}, spawnPC);
                if (sync) got(2'd2, syncGroup, 16'h0);
                if (memWrite) begin
                    wcount++;
                    got(2'd3, memWriteAddr, memWriteData);
                end
            end
        end
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        enable = 1'b0;
        doNextIns = 1'b0;
        overwrite = 1'b0;
        newPC = '0;
        sb.delete();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_run(input logic go);
        enable = 1'b1;
        doNextIns = go;
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {15'h0, halted}, 16'h1);
        repeat (2) @(negedge clk);
        chk({nm, "_sb_empty"}, sb.size(), 16'h0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        tbl[0] = '{16'h1312, 16'h0005, 16'h0007, 4'd1, 16'h000C};
        tbl[1] = '{16'h1312, 16'hFFFF, 16'h0002, 4'd1, 16'h0001};
        tbl[2] = '{16'h1312, 16'h8000, 16'h8000, 4'd1, 16'h0000};
        tbl[3] = '{16'h7125, 16'h0003, 16'h0004, 4'd2, 16'h0000};
        tbl[4] = '{16'h7125, 16'h0004, 16'h0004, 4'd1, 16'h0000};
        tbl[5] = '{16'h6125, 16'h0004, 16'h0004, 4'd2, 16'h0000};
        tbl[6] = '{16'h6125, 16'h0004, 16'h0005, 4'd1, 16'h0000};
        tbl[7] = '{16'h8125, 16'h0005, 16'h0004, 4'd2, 16'h0000};
        tbl[8] = '{16'h8125, 16'h0004, 16'h0005, 4'd1, 16'h0000};
        tbl[9] = '{16'h7125, 16'hFFFF, 16'h0001, 4'd1, 16'h0000};

        // reset state and the basic MOV/MOV/ADD/HALT timing
        hold_reset();
        chk("rst_ready", {15'h0, ready}, 16'h0);
        chk("rst_halted", {15'h0, halted}, 16'h0);
        chk("rst_memRead", {15'h0, memRead}, 16'h0);
        chk("rst_memAddr", memAddr, 16'h0);
        chk("rst_pulses", {13'h0, spawn, sync, memWrite}, 16'h0);
        mem[0] = 16'h0105;
        mem[1] = 16'h0207;
        mem[2] = 16'h1312;
        mem[3] = 16'h3000;
        release_run(1'b1);
        repeat (8) @(negedge clk);
        chk("halt_not_yet", {15'h0, halted}, 16'h0);
        @(negedge clk);
        chk("halt_at_9", {15'h0, halted}, 16'h1);
        chk("halt_ready", {15'h0, ready}, 16'h0);

        for (int i = 0; i < 10; i++) begin
            hold_reset();
            mem[16'h00] = 16'h41F0;
            mem[16'h01] = 16'h42F1;
            mem[16'h02] = 16'h0510;
            mem[16'h03] = tbl[i].ins;
            mem[16'h04] = 16'hB130;
            mem[16'h05] = 16'h3000;
            mem[16'h10] = 16'hB230;
            mem[16'h11] = 16'h3000;
            mem[16'hF0] = tbl[i].x;
            mem[16'hF1] = tbl[i].y;
            push(2'd1, {12'h0, tbl[i].eid}, tbl[i].epc);
            release_run(1'b1);
            wait_halt($sformatf("vec%0d", i), 60);
        end

        // LDR takes an extra MEM cycle reading the register address
        hold_reset();
        mem[0] = 16'h0120;
        mem[1] = 16'h5410;
        mem[2] = 16'hB040;
        mem[3] = 16'h3000;
        mem[16'h20] = 16'hBEEF;
        push(2'd1, 16'h0, 16'hBEEF);
        release_run(1'b1);
        repeat (5) @(negedge clk);
        chk("ldr_mem_read", {15'h0, memRead}, 16'h1);
        chk("ldr_mem_addr", memAddr, 16'h0020);
        chk("ldr_mem_ready", {15'h0, ready}, 16'h0);
        @(negedge clk);
        chk("ldr_next_fetch", memAddr, 16'h0002);
        wait_halt("ldr", 40);

        // withheld go, enable drop, spawn/sync, overwrite after halt
        hold_reset();
        mem[0] = 16'h0210;
        mem[1] = 16'hB320;
        mem[2] = 16'hA002;
        mem[3] = 16'h3000;
        mem[16'h30] = 16'hB520;
        mem[16'h31] = 16'h3000;
        release_run(1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wait_ready", {15'h0, ready}, 16'h1);
            chk("wait_no_read", {15'h0, memRead}, 16'h0);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("dis_ready", {15'h0, ready}, 16'h0);
        chk("dis_read", {15'h0, memRead}, 16'h0);
        push(2'd1, 16'h3, 16'h0010);
        push(2'd2, 16'h2, 16'h0000);
        enable = 1'b1;
        doNextIns = 1'b1;
        wait_halt("spawn_sync", 40);
        overwrite = 1'b1;
        newPC = 16'h0030;
        push(2'd1, 16'h5, 16'h0010);
        @(negedge clk);
        overwrite = 1'b0;
        chk("ow_halted", {15'h0, halted}, 16'h0);
        chk("ow_fetch", {15'h0, memRead}, 16'h1);
        chk("ow_addr", memAddr, 16'h0030);
        wait_halt("overwrite", 40);

        hold_reset();
        mem[0] = 16'h0109;
        mem[1] = 16'h0250;
        mem[2] = 16'hC120;
        mem[3] = 16'h3000;
        wcount = 0;
`ifdef GPU_CORE_STORE_EN
        push(2'd3, 16'h0050, 16'h0009);
`endif
        release_run(1'b1);
        wait_halt("store", 40);
`ifdef GPU_CORE_STORE_EN
        chk("store_count", wcount[15:0], 16'h1);
`else
        chk("store_count", wcount[15:0], 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
